id_stage_hz: RTL and testbench

- Parametrised successor to the MIPS ID stage: register file, immediate extension, early branch resolution in ID, load-use and branch hazard detection, and a registered ID/EX pipeline boundary.
- Sits between the IF/ID register and EX.
- Drives stall/flush back to IF.
- Carries saturating performance counters for stall cycles and taken-branch flushes.

---
 rtl/id_stage_hz.sv | 161 ++++++++++++++++
 tb/tb_id_stage_hz.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// rtl/id_stage_hz.sv - MIPS-style ID stage: register file, immediate extension, branch resolution, hazards, ID/EX register
// Define ID_BRANCH_FWD_EN to forward the MEM-stage result into branch comparison instead of stalling.
module id_stage_hz #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifid_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0]     mem_result,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  idex_valid,
  output logic [DATA_W-1:0]     idex_rs_data,
  output logic [DATA_W-1:0]     idex_rt_data,
  output logic [DATA_W-1:0]     idex_imm,
  output logic [REG_ADDR_W-1:0] idex_rs,
  output logic [REG_ADDR_W-1:0] idex_rt,
  output logic [REG_ADDR_W-1:0] idex_rd,
  output logic [5:0]            idex_opcode,
  output logic [5:0]            idex_func,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [5:0]            opcode;
  logic [5:0]            func;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm_f;
  logic [DATA_W-1:0]     ext_imm;
  logic [DATA_W-1:0]     rs_val;
  logic [DATA_W-1:0]     rt_val;
  logic [DATA_W-1:0]     br_a;
  logic [DATA_W-1:0]     br_b;
  logic                  is_branch;
  logic                  load_use;
  logic                  ex_match;
  logic                  mem_match;
  logic                  br_hazard;
  logic                  br_cond;

  assign opcode = instruction[31:26];
  assign rs     = REG_ADDR_W'(instruction[25:21]);
  assign rt     = REG_ADDR_W'(instruction[20:16]);
  assign rd     = REG_ADDR_W'(instruction[15:11]);
  assign func   = instruction[5:0];
  assign imm_f  = instruction[IMM_W-1:0];

  // Write-through read: a same-cycle WB write to the addressed register wins.
  function automatic logic [DATA_W-1:0] rf_read(input logic [REG_ADDR_W-1:0] a);
    if (a == '0)
      rf_read = '0;
    else if (wb_reg_write && wb_reg == a)
      rf_read = wb_data;
    else
      rf_read = regs[a];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_reg != '0) begin
      regs[wb_reg] <= wb_data;
    end
  end

`ifndef ID_BRANCH_FWD_EN
  logic unused_mem_result;
  assign unused_mem_result = ^mem_result;
`endif

  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      ext_imm = {{(DATA_W-IMM_W){1'b0}}, imm_f};
    else
      ext_imm = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};

    rs_val    = rf_read(rs);
    rt_val    = rf_read(rt);
    is_branch = ifid_valid && (opcode == OP_BEQ || opcode == OP_BNE);
    ex_match  = (ex_dst != '0) && (ex_dst == rs || ex_dst == rt);
    mem_match = (mem_dst != '0) && (mem_dst == rs || mem_dst == rt);
    load_use  = ifid_valid && ex_mem_read && ex_match;

`ifdef ID_BRANCH_FWD_EN
    br_hazard = is_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    br_a = (mem_reg_write && mem_dst != '0 && mem_dst == rs) ? mem_result : rs_val;
    br_b = (mem_reg_write && mem_dst != '0 && mem_dst == rt) ? mem_result : rt_val;
`else
    // Without the MEM result path, any pending MEM write to a branch source must drain first.
    br_hazard = is_branch && ((ex_reg_write && ex_match) ||
                              ((mem_mem_read || mem_reg_write) && mem_match));
    br_a = rs_val;
    br_b = rt_val;
`endif

    stall_o       = load_use || br_hazard;
    br_cond       = (opcode == OP_BEQ) ? (br_a == br_b) : (br_a != br_b);
    branch_taken  = is_branch && br_cond && !stall_o;
    flush_o       = branch_taken;
    branch_target = pc_plus4 + (ext_imm << 2);
  end

  always_ff @(posedge clk) begin
    if (rst || stall_o || !ifid_valid) begin
      idex_valid   <= 1'b0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
      idex_opcode  <= '0;
      idex_func    <= '0;
    end else begin
      idex_valid   <= 1'b1;
      idex_rs_data <= rs_val;
      idex_rt_data <= rt_val;
      idex_imm     <= ext_imm;
      idex_rs      <= rs;
      idex_rt      <= rt;
      idex_rd      <= rd;
      idex_opcode  <= opcode;
      idex_func    <= func;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_o && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb/tb_id_stage_hz.sv - scoreboard bench for id_stage_hz (directed vectors, narrow counters to reach saturation)
module tb_id_stage_hz;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifid_valid;
  logic [31:0]   instruction;
  logic [DW-1:0] pc_plus4;
  logic          wb_reg_write;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [AW-1:0] ex_dst;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_result;
  logic          stall_o;
  logic          flush_o;
  logic          branch_taken;
  logic [DW-1:0] branch_target;
  logic          idex_valid;
  logic [DW-1:0] idex_rs_data;
  logic [DW-1:0] idex_rt_data;
  logic [DW-1:0] idex_imm;
  logic [AW-1:0] idex_rs;
  logic [AW-1:0] idex_rt;
  logic [AW-1:0] idex_rd;
  logic [5:0]    idex_opcode;
  logic [5:0]    idex_func;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  always #5 clk = ~clk;

  id_stage_hz #(.DATA_W(DW), .REG_ADDR_W(AW), .IMM_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .instruction(instruction),
    .pc_plus4(pc_plus4), .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .mem_result(mem_result), .stall_o(stall_o), .flush_o(flush_o),
    .branch_taken(branch_taken), .branch_target(branch_target), .idex_valid(idex_valid),
    .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_opcode(idex_opcode),
    .idex_func(idex_func), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        taken;
    logic        chk_tgt;
    logic [31:0] tgt;
  } comb_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   rsd;
    logic [31:0]   rtd;
    logic [31:0]   imm;
    logic [26:0]   flds;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } idex_t;

  comb_t         comb_q[$];
  idex_t         idex_q[$];
  int            checks = 0;
  int            passes = 0;
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_fcnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic idle();
    rst = 1'b0; ifid_valid = 1'b0; instruction = '0; pc_plus4 = '0;
    wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_dst = '0; mem_result = '0;
  endtask

  // Queue this cycle's combinational expectation and the ID/EX contents after the next edge.
  task automatic issue(input logic st, input logic fl, input logic tk, input logic ct,
                       input logic [31:0] tgt, input logic v, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm);
    comb_t c;
    idex_t e;
    c.stall = st; c.flush = fl; c.taken = tk; c.chk_tgt = ct; c.tgt = tgt;
    if (rst) begin
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (st && m_scnt != '1) m_scnt = m_scnt + 1'b1;
      if (fl && m_fcnt != '1) m_fcnt = m_fcnt + 1'b1;
    end
    e.valid = v;
    e.rsd   = v ? rsd : '0;
    e.rtd   = v ? rtd : '0;
    e.imm   = v ? imm : '0;
    e.flds  = v ? {instruction[25:21], instruction[20:16], instruction[15:11],
                   instruction[31:26], instruction[5:0]} : '0;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    comb_q.push_back(c);
    idex_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("stall_o", 32'(stall_o), 32'(c.stall));
        chk("flush_o", 32'(flush_o), 32'(c.flush));
        chk("branch_taken", 32'(branch_taken), 32'(c.taken));
        if (c.chk_tgt) chk("branch_target", branch_target, c.tgt);
      end
    end
  end

  initial begin
    idex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (idex_q.size() > 0) begin
        e = idex_q.pop_front();
        chk("idex_valid", 32'(idex_valid), 32'(e.valid));
        chk("idex_rs_data", idex_rs_data, e.rsd);
        chk("idex_rt_data", idex_rt_data, e.rtd);
        chk("idex_imm", idex_imm, e.imm);
        chk("idex_fields", 32'({idex_rs, idex_rt, idex_rd, idex_opcode, idex_func}), 32'(e.flds));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle(); wb_reg_write = 1; wb_reg = 5; wb_data = 32'h1234;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 5, 6, 16'h0010);
    issue(0, 0, 0, 0, 0, 1, 32'h1234, 0, 32'h10);
    idle(); wb_reg_write = 1; wb_reg = 0; wb_data = 32'hFFFF;
    ifid_valid = 1; instruction = itype(6'h08, 0, 0, 16'h0000);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 0, 0, 16'h0000);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0);

    idle(); wb_reg_write = 1; wb_reg = 7; wb_data = 32'hA5A5;
    ifid_valid = 1; instruction = itype(6'h08, 7, 5, 16'h0000);
    issue(0, 0, 0, 0, 0, 1, 32'hA5A5, 32'h1234, 0);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 7, 0, 16'h0001);
    issue(0, 0, 0, 0, 0, 1, 32'hA5A5, 0, 32'h1);

    idle(); ex_mem_read = 1; ex_dst = 3; ifid_valid = 1; instruction = itype(6'h08, 1, 3, 16'h0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 1, 3, 16'h0);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(); ex_mem_read = 1; ex_dst = 0; ifid_valid = 1; instruction = itype(6'h08, 0, 0, 16'h7);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 32'h7);

    idle(); wb_reg_write = 1; wb_reg = 1; wb_data = 9;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); wb_reg_write = 1; wb_reg = 2; wb_data = 9;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle(); pc_plus4 = 32'h100; ifid_valid = 1; instruction = itype(6'h04, 1, 2, 16'hFFFE);
    issue(0, 1, 1, 1, 32'hF8, 1, 9, 9, 32'hFFFFFFFE);
    idle(); pc_plus4 = 32'h100; ifid_valid = 1; instruction = itype(6'h05, 1, 2, 16'hFFFE);
    issue(0, 0, 0, 1, 32'hF8, 1, 9, 9, 32'hFFFFFFFE);
    idle(); ex_reg_write = 1; ex_dst = 2; pc_plus4 = 32'h100;
    ifid_valid = 1; instruction = itype(6'h04, 1, 2, 16'hFFFE);
    issue(1, 0, 0, 1, 32'hF8, 0, 0, 0, 0);
    idle(); ex_reg_write = 1; ex_dst = 2; ifid_valid = 1; instruction = itype(6'h08, 1, 2, 16'h0);
    issue(0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(); mem_mem_read = 1; mem_dst = 1; pc_plus4 = 32'h100;
    ifid_valid = 1; instruction = itype(6'h04, 1, 2, 16'hFFFE);
    issue(1, 0, 0, 1, 32'hF8, 0, 0, 0, 0);

    idle(); wb_reg_write = 1; wb_reg = 1; wb_data = 0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); mem_reg_write = 1; mem_dst = 1; mem_result = 9; pc_plus4 = 32'h100;
    ifid_valid = 1; instruction = itype(6'h04, 1, 2, 16'hFFFE);
`ifdef ID_BRANCH_FWD_EN
    issue(0, 1, 1, 1, 32'hF8, 1, 0, 9, 32'hFFFFFFFE);
`else
    issue(1, 0, 0, 1, 32'hF8, 0, 0, 0, 0);
`endif

    idle(); ex_mem_read = 1; ex_dst = 5; ifid_valid = 1; instruction = itype(6'h08, 5, 0, 16'h0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0);

    idle(); ifid_valid = 1; instruction = itype(6'h0D, 0, 0, 16'h8000);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 32'h00008000);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 0, 0, 16'h8000);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF8000);
    idle(); ifid_valid = 1; instruction = itype(6'h0C, 0, 0, 16'hFFFF);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 32'h0000FFFF);
    idle(); ifid_valid = 1; instruction = itype(6'h0E, 0, 0, 16'hFFFF);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 32'h0000FFFF);

    idle(); rst = 1; ex_mem_read = 1; ex_dst = 5; ifid_valid = 1; instruction = itype(6'h08, 5, 0, 16'h0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); ifid_valid = 1; instruction = itype(6'h08, 5, 7, 16'h0);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0);

    idle();
    for (int i = 0; i < 20 && (comb_q.size() > 0 || idex_q.size() > 0); i++) @(negedge clk);
    if (comb_q.size() > 0 || idex_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d comb and %0d idex expectations left, expected 0", comb_q.size(), idex_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
